// File: rtl/alu_pkg.sv
// +----------------------------------------------------------------------------
// | alu_pkg : op encoding, FSM state type and default sizes for alu_unit
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 24;
  localparam int ALU_CNT_W = 5;

  localparam logic [2:0] OP_PASSB = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_AND   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// +----------------------------------------------------------------------------
// | alu_mul_seq : WIDTH-iteration shift-add multiplier, low WIDTH bits kept
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_mul_seq #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    acc_next = acc_q + (b_q[0] ? a_q : '0);
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done     = 1'b0;
    if (run_q) begin
      acc_d = acc_next;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_ITER) begin
        done  = 1'b1;
        run_d = 1'b0;
        cnt_d = '0;
      end
    end else if (start) begin
      a_d   = a_in;
      b_d   = b_in;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end
  end

  // Product already includes the final iteration so the caller can register it on done.
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_unit.sv
// +----------------------------------------------------------------------------
// | alu_unit : AC-side ALU with single-cycle ops, sequential MUL and flags.
// | Optional carry/borrow flag output when ALU_CARRY_FLAG_EN is defined.
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] ac_in,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             z_flag
`ifdef ALU_CARRY_FLAG_EN
  ,
  output logic             c_flag
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] alu_res;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = start && (state_q == ST_IDLE) && (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a_in    (ac_in),
    .b_in    (bus_in),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    alu_res = ac_in;
    case (op)
      OP_PASSB: alu_res = bus_in;
      OP_ADD:   alu_res = ac_in + bus_in;
      OP_SUB:   alu_res = ac_in - bus_in;
      OP_INC:   alu_res = ac_in + WIDTH'(1);
      OP_AND:   alu_res = ac_in & bus_in;
      OP_OR:    alu_res = ac_in | bus_in;
      default:  alu_res = ac_in;
    endcase
  end

`ifdef ALU_CARRY_FLAG_EN
  logic c_q, c_d;
  logic alu_carry;

  // A wrapped sum is smaller than either addend, which gives ADD carry without a wide adder.
  always_comb begin
    alu_carry = 1'b0;
    case (op)
      OP_ADD:  alu_carry = (alu_res < ac_in);
      OP_SUB:  alu_carry = (ac_in < bus_in);
      OP_INC:  alu_carry = &ac_in;
      default: alu_carry = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    done_d   = 1'b0;
`ifdef ALU_CARRY_FLAG_EN
    c_d      = c_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d = ST_MUL;
          end else begin
            result_d = alu_res;
            z_d      = (alu_res == '0);
            done_d   = 1'b1;
`ifdef ALU_CARRY_FLAG_EN
            c_d      = alu_carry;
`endif
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d  = ST_IDLE;
          result_d = mul_product;
          z_d      = (mul_product == '0);
          done_d   = 1'b1;
`ifdef ALU_CARRY_FLAG_EN
          c_d      = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
`ifdef ALU_CARRY_FLAG_EN
      c_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      z_q      <= z_d;
`ifdef ALU_CARRY_FLAG_EN
      c_q      <= c_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = (state_q == ST_MUL);
  assign z_flag = z_q;
`ifdef ALU_CARRY_FLAG_EN
  assign c_flag = c_q;
`endif

endmodule

`default_nettype wire
